spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one SPI master (2..8).
REQ-002 Parameter TIMEOUT, default 1023, maximum clk cycles to wait for spi_cs to fall after spi_newd is asserted.
REQ-003 clk  input  1  system clock; same clock that drives the SPI master.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request; level, held until that requester's ack.
REQ-006 req_data  input  NREQ*12  per-requester 12-bit word; slice i is bits [12i+11:12i].
REQ-007 ack  output  NREQ  one-cycle pulse; the word for requester i has been latched.
REQ-008 done  output  NREQ  one-cycle pulse; the transfer for requester i has completed (spi_cs has returned high).
REQ-009 err  output  1  one-cycle pulse on timeout abort.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 grant_id  output  3  index of the current or most recent granted requester.
REQ-012 spi_newd  output  1  to master newd.
REQ-013 spi_din  output  12  to master din; stable while spi_newd is high.
REQ-014 spi_cs  input  1  master chip select, active-low; the transfer is in progress while low.

Function
REQ-015 States: IDLE, ISSUE, XFER, CLEAN.
REQ-016 IDLE with any req bit high -> select a winner by round-robin, latch its req_data into spi_din, pulse ack[winner], set grant_id, and go to ISSUE on the next cycle.
REQ-017 Round-robin order: search starts at (last_grant+1) mod NREQ and the lowest index at or after the start wins; after reset last_grant = NREQ-1, so requester 0 has highest priority first.
REQ-018 ISSUE: spi_newd = 1 and a timeout counter increments each cycle.
- On the first cycle spi_cs is sampled 0: deassert spi_newd and go to XFER.
- If the counter reaches TIMEOUT first: deassert spi_newd, pulse err, and go to CLEAN; no done pulse is issued.
REQ-019 XFER: on the first cycle spi_cs is sampled 1, pulse done[grant_id], then go to CLEAN.
REQ-020 CLEAN: lasts exactly one cycle, then go to IDLE; no grant can occur in CLEAN.
REQ-021 spi_cs is registered once before use, and all transitions use the registered value.
REQ-022 Latency from req (IDLE, only requester) to ack is 1 cycle, and from ack to spi_newd high is 1 cycle.
REQ-023 Requests arriving while busy are held pending and are arbitrated on the first IDLE cycle.
REQ-024 A req bit dropped before its ack is ignored; req_data is sampled only in the grant cycle.
REQ-025 A requester re-asserting req immediately after its done is granted only after all other pending requesters (fairness).
REQ-026 At most one ack bit and at most one done bit is high in any cycle.
REQ-027 The timeout counter is 11 bits wide, clears on entry to ISSUE, and saturates at TIMEOUT.

Reset
REQ-028 On rst: state = IDLE, spi_newd = 0, spi_din = 0, ack = 0, done = 0, err = 0, busy = 0, grant_id = 0, last_grant = NREQ-1, counter = 0.
REQ-029 rst mid-transfer forces IDLE on the next cycle with no done or err pulse; recovery of the SPI master is the master's own reset.

Verification
REQ-030 Single requester: req[2] = 1, data 0xA5C -> ack[2] at +1 cycle; spi_newd high with spi_din = 0xA5C until spi_cs falls; done[2] one cycle after spi_cs rises; busy drops after CLEAN.
REQ-031 All four req high from reset -> grant order 0, 1, 2, 3, with exactly one done per requester in that order.
REQ-032 req[1] held continuously while req[3] is pending -> after done[1] the next grant is 3, not 1.
REQ-033 spi_cs tied high -> err pulse exactly TIMEOUT cycles after spi_newd rises; spi_newd is low the next cycle; no done pulse; the next request is serviced normally.
REQ-034 rst asserted while in XFER -> next cycle busy = 0, no done pulse; a subsequent req[0] is granted, since last_grant has reset.
REQ-035 req[0] pulses for one cycle while the arbiter is busy, then drops -> no ack[0] is issued.

Source files
------------

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Shares one SPI master between NREQ requesters. An idle arbiter picks a
// winner round-robin, latches its 12-bit word onto spi_din and acknowledges
// it. It then raises spi_newd until the master pulls spi_cs low, waits for
// spi_cs to return high, reports completion and passes through a one-cycle
// CLEAN state before it can grant again. If the master never starts, the
// request is aborted after TIMEOUT cycles of spi_newd.
//
// Ports
//   clk       system clock (also clocks the SPI master)
//   rst       synchronous, active-high reset
//   req       per-requester level request, held until ack
//   req_data  per-requester 12-bit words, slice i = [12i+11:12i]
//   ack       one-cycle pulse: word of requester i latched
//   done      one-cycle pulse: transfer of requester i finished
//   err       one-cycle pulse: master never asserted spi_cs (timeout)
//   busy      high whenever the arbiter is not idle
//   grant_id  current / most recent granted requester
//   spi_newd  new-data strobe to the master
//   spi_din   data word to the master, stable while spi_newd is high
//   spi_cs    master chip select (active low), registered before use
// -----------------------------------------------------------------------------
module spi_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*12-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               spi_newd,
    output logic [11:0]        spi_din,
    input  logic               spi_cs
);

    localparam logic [10:0]     TIMEOUT_C = 11'(TIMEOUT);
    localparam logic [2:0]      LAST_ID   = 3'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_C     = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        CLEAN = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t          state_q,      state_d;
    logic            spi_newd_q,   spi_newd_d;
    logic [11:0]     spi_din_q,    spi_din_d;
    logic [NREQ-1:0] ack_q,        ack_d;
    logic [NREQ-1:0] done_q,       done_d;
    logic            err_q,        err_d;
    logic [2:0]      grant_id_q,   grant_id_d;
    logic [2:0]      last_grant_q, last_grant_d;
    logic [10:0]     cnt_q,        cnt_d;
    logic            spi_cs_q,     spi_cs_d;

    // -------------------------------------------------------------------------
    // Round-robin winner selection
    //
    // Requests at or above the start index form the "high" set. The lowest
    // set bit of the high set wins; if it is empty, the lowest set bit of the
    // full request vector wins (wrap-around). Lowest set bit is isolated with
    // the two's-complement trick v & -v.
    // -------------------------------------------------------------------------
    logic [2:0]             start_id;
    logic [NREQ-1:0]        mask_hi;
    logic [NREQ-1:0]        req_hi;
    logic [NREQ-1:0]        oh_hi;
    logic [NREQ-1:0]        oh_all;
    logic [NREQ-1:0]        win_oh;
    logic [2:0][NREQ-1:0]   id_col;
    logic [11:0][NREQ-1:0]  data_col;
    logic [2:0]             win_id;
    logic [11:0]            win_data;
    logic [NREQ-1:0]        grant_oh;

    assign start_id = (last_grant_q == LAST_ID) ? 3'd0 : last_grant_q + 3'd1;

    genvar gi, gb;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign mask_hi[gi]  = (3'(gi) >= start_id);
            assign grant_oh[gi] = (grant_id_q == 3'(gi));

            // Column gb of id_col holds bit gb of each requester's index, so
            // an AND-OR with a one-hot vector encodes it without a priority
            // loop.
            for (gb = 0; gb < 3; gb++) begin : g_idbit
                assign id_col[gb][gi] = (((gi >> gb) % 2) != 0);
            end

            // Same transposition for the data words.
            for (gb = 0; gb < 12; gb++) begin : g_dbit
                assign data_col[gb][gi] = req_data[12*gi + gb];
            end
        end

        for (gb = 0; gb < 3; gb++) begin : g_win_id
            assign win_id[gb] = |(win_oh & id_col[gb]);
        end

        for (gb = 0; gb < 12; gb++) begin : g_win_data
            assign win_data[gb] = |(win_oh & data_col[gb]);
        end
    endgenerate

    assign req_hi = req & mask_hi;
    assign oh_hi  = req_hi & (~req_hi + ONE_C);
    assign oh_all = req & (~req + ONE_C);
    assign win_oh = (|req_hi) ? oh_hi : oh_all;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        spi_newd_d   = spi_newd_q;
        spi_din_d    = spi_din_q;
        ack_d        = '0;
        done_d       = '0;
        err_d        = 1'b0;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        spi_cs_d     = spi_cs;

        case (state_q)
            IDLE: begin
                // Only requests still high in this cycle compete; data is
                // sampled here and nowhere else.
                if (|req) begin
                    ack_d        = win_oh;
                    spi_din_d    = win_data;
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                if (!spi_cs_q) begin
                    spi_newd_d = 1'b0;
                    state_d    = XFER;
                end else if (cnt_q == TIMEOUT_C) begin
                    spi_newd_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = CLEAN;
                end else begin
                    // The compare above stops the count at TIMEOUT, so the
                    // increment never passes it.
                    spi_newd_d = 1'b1;
                    cnt_d      = cnt_q + 11'd1;
                end
            end

            XFER: begin
                if (spi_cs_q) begin
                    done_d  = grant_oh;
                    state_d = CLEAN;
                end
            end

            CLEAN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            spi_newd_q   <= 1'b0;
            spi_din_q    <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= LAST_ID;
            cnt_q        <= '0;
            // Chip select idles high; starting high avoids a false
            // "transfer started" right after reset.
            spi_cs_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            spi_newd_q   <= spi_newd_d;
            spi_din_q    <= spi_din_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            spi_cs_q     <= spi_cs_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ack      = ack_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_id_q;
    assign spi_newd = spi_newd_q;
    assign spi_din  = spi_din_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
//
// Scoreboard bench for spi_arbiter. Each stimulus step pushes the expected
// grant (requester id and data word) onto a queue; ack pulses pop and compare
// it, and move the id onto a pending-done queue that done/err pulses consume.
// A small behavioural SPI master answers spi_newd by pulling spi_cs low for a
// few cycles, or holds spi_cs high to force the timeout path.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*12-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    done;
    logic               err;
    logic               busy;
    logic [2:0]         grant_id;
    logic               spi_newd;
    logic [11:0]        spi_din;
    logic               spi_cs;

    always #5 clk = ~clk;

    spi_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .spi_newd (spi_newd),
        .spi_din  (spi_din),
        .spi_cs   (spi_cs)
    );

    // Bookkeeping
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cycle     = 0;
    int          exp_id_q[$];
    logic [11:0] exp_data_q[$];
    int          done_q[$];
    logic [NREQ-1:0] hold  = '0;
    logic [11:0] cur_data  = '0;
    int          newd_rise = 0;
    bit          newd_prev = 0;
    bit          chk_newd_hi = 0;
    bit          chk_newd_lo = 0;
    bit          expect_err  = 0;
    bit          cs_stuck    = 0;
    int          m_state   = 0;
    int          m_cnt     = 0;
    int          n_done    = 0;
    int          exp_dones = 0;
    int          n_err     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cycle);
        end
    endtask

    function automatic int oh_index(input logic [NREQ-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic set_data(input int i, input logic [11:0] v);
        req_data[12*i +: 12] = v;
    endtask

    task automatic push_exp(input int id, input logic [11:0] d);
        exp_id_q.push_back(id);
        exp_data_q.push_back(d);
        exp_dones++;
    endtask

    // Observes DUT outputs one time unit after the clock edge and reacts as
    // the requesters and the SPI master would.
    task automatic monitor();
        int          id;
        int          e_id;
        logic [11:0] e_data;

        if (chk_newd_hi) begin
            check("newd_after_ack", spi_newd, 1);
            chk_newd_hi = 0;
        end
        if (chk_newd_lo) begin
            check("newd_after_err", spi_newd, 0);
            chk_newd_lo = 0;
        end

        if (ack != '0) begin
            id = oh_index(ack);
            $display("cycle %0d: ack id=%0d din=0x%03h grant_id=%0d", cycle, id, spi_din, grant_id);
            check("ack_onehot", $countones(ack), 1);
            if (exp_id_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 0);
            end else begin
                e_id   = exp_id_q.pop_front();
                e_data = exp_data_q.pop_front();
                check("ack_id", id, e_id);
                check("ack_data", spi_din, e_data);
                check("grant_id", grant_id, e_id);
                cur_data = e_data;
                done_q.push_back(e_id);
                chk_newd_hi = 1;
            end
            if (!hold[id]) req[id] = 1'b0;
        end

        if (spi_newd) begin
            check("din_stable", spi_din, cur_data);
            if (!newd_prev) newd_rise = cycle;
        end

        if (done != '0) begin
            id = oh_index(done);
            n_done++;
            $display("cycle %0d: done id=%0d", cycle, id);
            check("done_onehot", $countones(done), 1);
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'(done), 0);
            end else begin
                e_id = done_q.pop_front();
                check("done_id", id, e_id);
            end
        end

        if (err) begin
            n_err++;
            $display("cycle %0d: err (timeout abort)", cycle);
            check("err_expected", expect_err, 1);
            check("err_latency", cycle - newd_rise, TMO);
            if (done_q.size() != 0) void'(done_q.pop_front());
            expect_err  = 0;
            chk_newd_lo = 1;
        end

        // Behavioural SPI master
        if (cs_stuck) begin
            spi_cs = 1'b1;
        end else begin
            case (m_state)
                0: if (spi_newd) begin
                    m_state = 1;
                    m_cnt   = 2;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        spi_cs  = 1'b0;
                        m_state = 2;
                        m_cnt   = 3;
                    end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        spi_cs  = 1'b1;
                        m_state = 0;
                    end
                end
            endcase
        end

        newd_prev = spi_newd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        monitor();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        spi_cs  = 1'b1;
        m_state = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(busy == 1'b0 && exp_id_q.size() == 0 && done_q.size() == 0 && req == '0) && k < 400);
        $display("cycle %0d: %s settled after %0d cycles", cycle, tag, k);
        check("idle_busy", busy, 0);
        check("idle_pending_acks", exp_id_q.size(), 0);
        check("idle_pending_dones", done_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  k;
        bit  seen_hi;

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        spi_cs   = 1'b1;
        step();
        step();
        step();
        // Reset values
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_newd", spi_newd, 0);
        check("rst_din", spi_din, 0);
        check("rst_grant_id", grant_id, 0);
        rst = 1'b0;
        step();

        // Single requester: 1-cycle ack, 1-cycle newd, data held stable
        set_data(2, 12'hA5C);
        push_exp(2, 12'hA5C);
        req[2] = 1'b1;
        step();
        check("ack_latency", ack, 4'b0100);
        step();
        check("newd_latency", spi_newd, 1);
        set_data(2, 12'hFFF);
        wait_idle("single");

        // All four from reset: order 0,1,2,3
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_data(i, 12'(12'h100 + i));
            push_exp(i, 12'(12'h100 + i));
        end
        req = 4'b1111;
        wait_idle("all_four");

        // Fairness: req[1] held while req[3] pending -> 1, 3, then 1 again
        hold[1] = 1'b1;
        set_data(1, 12'h111);
        set_data(3, 12'h333);
        push_exp(1, 12'h111);
        push_exp(3, 12'h333);
        push_exp(1, 12'h111);
        req[1] = 1'b1;
        req[3] = 1'b1;
        k = 0;
        while (exp_id_q.size() > 1 && k < 200) begin
            step();
            k++;
        end
        hold[1] = 1'b0;
        wait_idle("fairness");

        // req[0] pulsed for one cycle while busy must not be granted
        set_data(2, 12'h2B2);
        push_exp(2, 12'h2B2);
        req[2] = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!busy && k < 20);
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        wait_idle("drop_while_busy");

        // Timeout: spi_cs held high
        cs_stuck   = 1;
        expect_err = 1;
        set_data(3, 12'h3C3);
        push_exp(3, 12'h3C3);
        exp_dones--;
        req[3] = 1'b1;
        wait_idle("timeout");
        check("err_consumed", expect_err, 0);
        cs_stuck = 0;
        set_data(0, 12'h0F0);
        push_exp(0, 12'h0F0);
        req[0] = 1'b1;
        wait_idle("after_timeout");

        // Reset during XFER: no done, last_grant back to NREQ-1
        set_data(1, 12'h1E1);
        push_exp(1, 12'h1E1);
        exp_dones--;
        req[1] = 1'b1;
        seen_hi = 0;
        k = 0;
        while (k < 100) begin
            step();
            k++;
            if (spi_newd) seen_hi = 1;
            else if (seen_hi) break;
        end
        check("xfer_reached", seen_hi, 1);
        rst     = 1'b1;
        spi_cs  = 1'b1;
        m_state = 0;
        done_q.delete();
        step();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_newd", spi_newd, 0);
        check("midrst_grant_id", grant_id, 0);
        rst = 1'b0;
        step();
        set_data(0, 12'h0AA);
        set_data(3, 12'h3BB);
        push_exp(0, 12'h0AA);
        push_exp(3, 12'h3BB);
        req[0] = 1'b1;
        req[3] = 1'b1;
        wait_idle("after_midrst");

        check("total_dones", n_done, exp_dones);
        check("total_errs", n_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
